// File: rtl/tac_pulse_encoder.sv
// Serialises one signed activation per frame into |x| tac_in pulses over 2^(DATA_W-1) cycles, plus sign and framing strobes.
// Outputs are registered and valid the cycle after accept. in_ready is high only in IDLE, or on the last RUN cycle when GAP_CYCLES=0.
module tac_pulse_encoder #(
  parameter int DATA_W     = 8,
  parameter int SPREAD     = 1,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] x_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  output logic              tac_in,
  output logic              sign_x,
  output logic              frame_start,
  output logic              frame_last,
  output logic              busy
);

  localparam int CW = DATA_W - 1;
  localparam logic [CW-1:0] CNT_LAST = '1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_GAP
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [CW-1:0]   r_mag, w_mag_nxt;
  logic [GW-1:0]   r_gap, w_gap_nxt;
  logic [CW-1:0]   w_mag_in;
  logic [CW-1:0]   w_cnt_pos;
  logic [DATA_W-1:0] w_abs;
  logic            w_neg;
  logic            w_ready;
  logic            w_xfer;
  logic            w_sign_nxt;
  logic            r_tac, r_sign, r_fs, r_fl, r_busy;

  // Only the most negative input overflows the magnitude field; clamp it to F-1.
  assign w_neg    = x_in[DATA_W-1];
  assign w_abs    = w_neg ? (~x_in + DATA_W'(1)) : x_in;
  assign w_mag_in = w_abs[DATA_W-1] ? CNT_LAST : w_abs[CW-1:0];

  assign w_ready = !rst && !flush &&
                   ((r_state == S_IDLE) ||
                    ((GAP_CYCLES == 0) && (r_state == S_RUN) && (r_cnt == CNT_LAST)));
  assign w_xfer  = in_valid && w_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_gap_nxt   = r_gap;
    w_mag_nxt   = r_mag;
    w_sign_nxt  = r_sign;
    if (w_xfer) begin
      w_mag_nxt  = w_mag_in;
      w_sign_nxt = w_neg;
    end
    if (flush) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_gap_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            w_state_nxt = S_RUN;
            w_cnt_nxt   = '0;
          end
        end
        S_RUN: begin
          if (r_cnt == CNT_LAST) begin
            w_cnt_nxt = '0;
            w_gap_nxt = '0;
            if (w_xfer)
              w_state_nxt = S_RUN;
            else if (GAP_CYCLES > 0)
              w_state_nxt = S_GAP;
            else
              w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        S_GAP: begin
          if (r_gap == GAP_LAST) begin
            w_state_nxt = S_IDLE;
            w_gap_nxt   = '0;
          end else begin
            w_gap_nxt = r_gap + GW'(1);
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_gap_nxt   = '0;
        end
      endcase
    end
  end

  // Bit-reversing the slot index spreads the |x| ones evenly across the frame.
  always_comb begin
    w_cnt_pos = '0;
    for (int i = 0; i < CW; i++) begin
      w_cnt_pos[i] = (SPREAD != 0) ? w_cnt_nxt[CW-1-i] : w_cnt_nxt[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_gap   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gap   <= w_gap_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mag  <= '0;
      r_sign <= 1'b0;
      r_tac  <= 1'b0;
      r_fs   <= 1'b0;
      r_fl   <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_mag  <= w_mag_nxt;
      r_sign <= w_sign_nxt;
      r_tac  <= (w_state_nxt == S_RUN) && (w_cnt_pos < w_mag_nxt);
      r_fs   <= (w_state_nxt == S_RUN) && (w_cnt_nxt == '0);
      r_fl   <= (w_state_nxt == S_RUN) && (w_cnt_nxt == CNT_LAST);
      r_busy <= (w_state_nxt != S_IDLE);
    end
  end

  assign in_ready    = w_ready;
  assign tac_in      = r_tac;
  assign sign_x      = r_sign;
  assign frame_start = r_fs;
  assign frame_last  = r_fl;
  assign busy        = r_busy;

endmodule

// File: tb/tb_tac_pulse_encoder.sv
// Bench for tac_pulse_encoder: three instances (burst/gap2, spread/gap2, spread/gap0) against a frame-position model.
module tb_tac_pulse_encoder;

  localparam int DW = 8;
  localparam int F  = 128;
  localparam int N  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          flush;
  logic [DW-1:0] x_in     [N];
  logic          in_valid [N];
  logic          in_ready [N];
  logic          tac      [N];
  logic          sgn      [N];
  logic          fs       [N];
  logic          fl       [N];
  logic          busy     [N];

  tac_pulse_encoder #(.DATA_W(DW), .SPREAD(0), .GAP_CYCLES(2)) u0 (
    .clk(clk), .rst(rst), .x_in(x_in[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .flush(flush), .tac_in(tac[0]), .sign_x(sgn[0]), .frame_start(fs[0]),
    .frame_last(fl[0]), .busy(busy[0]));
  tac_pulse_encoder #(.DATA_W(DW), .SPREAD(1), .GAP_CYCLES(2)) u1 (
    .clk(clk), .rst(rst), .x_in(x_in[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .flush(flush), .tac_in(tac[1]), .sign_x(sgn[1]), .frame_start(fs[1]),
    .frame_last(fl[1]), .busy(busy[1]));
  tac_pulse_encoder #(.DATA_W(DW), .SPREAD(1), .GAP_CYCLES(0)) u2 (
    .clk(clk), .rst(rst), .x_in(x_in[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .flush(flush), .tac_in(tac[2]), .sign_x(sgn[2]), .frame_start(fs[2]),
    .frame_last(fl[2]), .busy(busy[2]));

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic int spr_of(input int i);
    return (i == 0) ? 0 : 1;
  endfunction

  function automatic int gap_of(input int i);
    return (i == 2) ? 0 : 2;
  endfunction

  // Slot k of a frame carries a pulse when its placement rank is below the magnitude.
  function automatic int place(input int i, input int k);
    int r;
    if (spr_of(i) == 0) return k;
    r = 0;
    for (int b = 0; b < DW - 1; b++)
      if (((k >> b) & 1) == 1) r += 1 << (DW - 2 - b);
    return r;
  endfunction

  function automatic int mag_of(input logic [DW-1:0] x);
    int v;
    v = int'($signed(x));
    if (v < 0) v = -v;
    if (v > F - 1) v = F - 1;
    return v;
  endfunction

  // pos: 0 idle, 1..F frame cycles, F+1..F+gap idle gap after the frame.
  int pos  [N] = '{0, 0, 0};
  int mmag [N] = '{0, 0, 0};
  bit msgn [N] = '{0, 0, 0};

  function automatic bit mready(input int i);
    return !rst && !flush && (pos[i] == 0 || (gap_of(i) == 0 && pos[i] == F));
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      bit xf;
      xf = in_valid[i] && mready(i);
      if (rst) begin
        pos[i] = 0; mmag[i] = 0; msgn[i] = 0;
      end else if (flush) begin
        pos[i] = 0;
      end else if (xf) begin
        pos[i] = 1; mmag[i] = mag_of(x_in[i]); msgn[i] = x_in[i][DW-1];
      end else if (pos[i] != 0) begin
        pos[i] = pos[i] + 1;
        if (pos[i] > F + gap_of(i)) pos[i] = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        bit in_frame;
        in_frame = (pos[i] >= 1 && pos[i] <= F);
        chk($sformatf("u%0d.tac_in", i), tac[i],
            (in_frame && place(i, pos[i] - 1) < mmag[i]) ? 1 : 0);
        chk($sformatf("u%0d.sign_x", i), sgn[i], msgn[i]);
        chk($sformatf("u%0d.frame_start", i), fs[i], (pos[i] == 1) ? 1 : 0);
        chk($sformatf("u%0d.frame_last", i), fl[i], (pos[i] == F) ? 1 : 0);
        chk($sformatf("u%0d.busy", i), busy[i], (pos[i] != 0) ? 1 : 0);
        chk($sformatf("u%0d.in_ready", i), in_ready[i], mready(i));
      end
    end
  end

  int o_ones, o_first, o_last, o_run, o_maxrun;
  int o_fs_cnt, o_fs_first, o_fl_cnt, o_fl_last, o_rdy_first;
  bit o_sign;

  task automatic observe(input int i, input int n);
    o_ones = 0; o_first = 0; o_last = 0; o_run = 0; o_maxrun = 0;
    o_fs_cnt = 0; o_fs_first = 0; o_fl_cnt = 0; o_fl_last = 0; o_rdy_first = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (k == 1) o_sign = sgn[i];
      if (tac[i]) begin
        o_ones++;
        if (o_first == 0) o_first = k;
        o_last = k;
        o_run++;
        if (o_run > o_maxrun) o_maxrun = o_run;
      end else begin
        o_run = 0;
      end
      if (fs[i]) begin
        o_fs_cnt++;
        if (o_fs_first == 0) o_fs_first = k;
      end
      if (fl[i]) begin
        o_fl_cnt++;
        o_fl_last = k;
      end
      if (in_ready[i] && o_rdy_first == 0) o_rdy_first = k;
    end
  endtask

  // Returns at posedge+2 of the accepting edge, i.e. inside frame cycle 1.
  task automatic send(input int i, input logic [DW-1:0] x, input bit keep);
    bit done;
    done = 1'b0;
    x_in[i] = x;
    in_valid[i] = 1'b1;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      if (in_ready[i]) done = 1'b1;
      @(posedge clk);
      #2;
    end
    if (!keep) in_valid[i] = 1'b0;
    if (!done) chk($sformatf("u%0d.accept_timeout", i), 0, 1);
  endtask

  function automatic logic [DW-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 8'h80;
      1: return 8'h00;
      2: return 8'h7F;
      3: return 8'hFF;
      4: return 8'h01;
      default: return DW'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    bit rdy [N];
    rst = 1'b1;
    flush = 1'b0;
    for (int i = 0; i < N; i++) begin
      x_in[i] = '0;
      in_valid[i] = 1'b0;
    end
    @(posedge clk); #2;
    chk_en = 1'b1;
    @(posedge clk); #2;
    @(negedge clk);
    chk("reset.in_ready", in_ready[0], 0);
    chk("reset.busy", busy[0], 0);
    chk("reset.tac_in", tac[0], 0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset.in_ready", in_ready[0], 1);
    @(posedge clk); #2;

    // burst placement, x=5
    send(0, 8'd5, 1'b0);
    observe(0, 131);
    chk("x5.ones", o_ones, 5);
    chk("x5.first_one", o_first, 1);
    chk("x5.last_one", o_last, 5);
    chk("x5.sign", o_sign, 0);
    chk("x5.fs_cycle", o_fs_first, 1);
    chk("x5.fs_count", o_fs_cnt, 1);
    chk("x5.fl_cycle", o_fl_last, 128);
    chk("x5.fl_count", o_fl_cnt, 1);
    chk("x5.ready_cycle", o_rdy_first, 131);

    // spread placement, x=-37
    send(1, 8'hDB, 1'b0);
    observe(1, 128);
    chk("xm37.ones", o_ones, 37);
    chk("xm37.max_run_le2", (o_maxrun <= 2) ? 1 : 0, 1);
    chk("xm37.sign", o_sign, 1);

    send(1, 8'h80, 1'b0);
    observe(1, 128);
    chk("xm128.ones", o_ones, 127);
    chk("xm128.sign", o_sign, 1);

    send(1, 8'h00, 1'b0);
    observe(1, 128);
    chk("x0.ones", o_ones, 0);
    chk("x0.sign", o_sign, 0);
    chk("x0.fs_count", o_fs_cnt, 1);
    chk("x0.fl_count", o_fl_cnt, 1);

    // back-to-back frames with no gap
    send(2, 8'd3, 1'b1);
    x_in[2] = 8'd100;
    observe(2, 128);
    chk("b2b.ones1", o_ones, 3);
    chk("b2b.fl1_cycle", o_fl_last, 128);
    chk("b2b.ready_cycle", o_rdy_first, 128);
    @(posedge clk); #2;
    in_valid[2] = 1'b0;
    observe(2, 128);
    chk("b2b.ones2", o_ones, 100);
    chk("b2b.fs2_cycle", o_fs_first, 1);
    chk("b2b.fl2_cycle", o_fl_last, 128);

    // flush on cycle 40 of a magnitude-90 burst frame
    send(0, 8'd90, 1'b0);
    repeat (39) begin
      @(posedge clk); #2;
    end
    flush = 1'b1;
    @(negedge clk);
    chk("flush.tac_c40", tac[0], 1);
    @(posedge clk); #2;
    flush = 1'b0;
    observe(0, 100);
    chk("flush.ones_after", o_ones, 0);
    chk("flush.fl_count", o_fl_cnt, 0);
    chk("flush.ready_cycle", o_rdy_first, 1);
    send(0, 8'd7, 1'b0);
    observe(0, 128);
    chk("restart.ones", o_ones, 7);
    chk("restart.fs_cycle", o_fs_first, 1);
    chk("restart.fl_cycle", o_fl_last, 128);

    // reset on cycle 60 of a negative frame
    send(1, 8'hCE, 1'b0);
    repeat (59) begin
      @(posedge clk); #2;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rst.in_ready_idle_unit", in_ready[0], 0);
    chk("rst.sign_before", sgn[1], 1);
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    chk("rst.busy", busy[1], 0);
    chk("rst.sign", sgn[1], 0);
    chk("rst.tac_in", tac[1], 0);
    chk("rst.in_ready", in_ready[1], 1);
    @(posedge clk); #2;

    // randomized traffic with occasional flush and reset
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) rdy[i] = in_ready[i];
      @(posedge clk); #2;
      for (int i = 0; i < N; i++) begin
        if (in_valid[i] && rdy[i]) in_valid[i] = 1'b0;
        if (!in_valid[i] && $urandom_range(0, 3) == 0) begin
          in_valid[i] = 1'b1;
          x_in[i] = pick();
        end
      end
      flush = ($urandom_range(0, 299) == 0);
      rst   = ($urandom_range(0, 799) == 0);
    end
    for (int i = 0; i < N; i++) in_valid[i] = 1'b0;
    flush = 1'b0;
    rst = 1'b0;
    repeat (300) @(posedge clk);
    #2;
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tac_pulse_encoder.md
Name: tac_pulse_encoder

Overview:
- Upstream feeder for the signed temporal-accumulation neuron.
- Accepts one signed two's-complement activation per frame through a valid/ready handshake and converts it to sign-magnitude.
- Drives the neuron's serial tac_in input with exactly |x| high cycles per fixed-length frame, and holds sign_x stable for the whole frame.
- Emits frame framing strobes so the controller can sample the neuron's dout and sequence the weight and bias.

Parameters:
- DATA_W, 8: activation width, two's complement.
- SPREAD, 1: pulse placement. 0 = unary burst (ones first). 1 = bit-reversed spread.
- GAP_CYCLES, 2: idle cycles after each frame for neuron readout/reset. 0 allowed.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- x_in  in  DATA_W  signed activation.
- in_valid  in  1  x_in valid.
- in_ready  out  1  encoder can accept x_in.
- flush  in  1  synchronous abort of the current frame.
- tac_in  out  1  serial pulse to neuron.
- sign_x  out  1  sign of the activation for the current frame.
- frame_start  out  1  one-cycle strobe on the first frame cycle.
- frame_last  out  1  one-cycle strobe on the final frame cycle.
- busy  out  1  high in RUN or GAP.

Behaviour:
- Frame length is F = 2^(DATA_W-1) cycles (128 at default). The counter cnt is (DATA_W-1) bits.
- Magnitude rules:
  - mag = x_in[MSB] ? -x_in : x_in, taking DATA_W-1 bits.
  - x_in = -2^(DATA_W-1) saturates to mag = F-1 (127) with sign 1.
  - x_in = 0 gives mag 0 and sign 0.
- Acceptance: a transfer occurs when in_valid && in_ready at a rising edge. mag and sign are captured into registers on that edge.
- States:
  - IDLE: in_ready=1 (0 while rst is high), tac_in=0. On transfer go to RUN with cnt=0.
  - RUN: cnt increments each cycle.
    - SPREAD=0: tac_in = (cnt < mag).
    - SPREAD=1: tac_in = (bitrev(cnt) < mag).
    - In both modes exactly mag ones per frame.
    - When cnt=F-1: go to GAP if GAP_CYCLES>0, else to IDLE.
  - GAP: tac_in=0, in_ready=0, counts GAP_CYCLES cycles, then IDLE.
- Back-to-back: with GAP_CYCLES=0, in_ready is also 1 on the RUN cycle with cnt=F-1. A transfer there starts the next frame with no bubble: cnt wraps to 0 and frame_start asserts next cycle.
- Outputs are registered. For a transfer at edge t:
  - tac_in, sign_x and frame_start are valid for the cycle after t.
  - frame_last asserts on the F-th cycle after t.
- frame_start and frame_last are never both high at default widths.
- sign_x holds its frame value through GAP and IDLE until the next transfer.
- Zero magnitude: the frame still runs the full F cycles with tac_in=0 and both strobes asserted.
- flush:
  - Next state is IDLE, cnt=0, tac_in=0 from the next cycle; no frame_last is emitted.
  - flush together with in_valid in IDLE: flush wins and nothing is accepted.
- rst:
  - Reset values: state=IDLE, cnt=0, tac_in=0, sign_x=0, frame_start=0, frame_last=0, busy=0, mag reg=0.
  - Reset mid-frame discards the frame.
  - rst has priority over flush and the handshake.
- in_valid while busy (except the back-to-back case) is ignored. The upstream source holds x_in and in_valid until accepted.

Test Plan:
- x_in=8'd5, SPREAD=0, GAP=2 -> tac_in high on cycles 1-5 after accept, low on 6-128. sign_x=0. frame_start on cycle 1, frame_last on cycle 128. in_ready low until cycle 131.
- x_in=-8'd37, SPREAD=1 -> 37 ones in 128 cycles, sign_x=1. No run of ones longer than 2. Pattern matches bitrev(cnt)<37.
- x_in=-128 -> sign_x=1, 127 ones. x_in=0 -> 0 ones, sign_x=0, strobes still present.
- GAP_CYCLES=0, in_valid held high with 3, then 100 -> frames abut with no idle cycle. One-counts are 3 then 100. frame_start follows frame_last directly.
- flush at cycle 40 of a 90-magnitude frame -> tac_in=0 from cycle 41, no frame_last. in_ready=1 next cycle, and a new accept restarts cleanly.
- rst pulsed at cycle 60 mid-frame -> all outputs at reset values the cycle after. in_ready=0 while rst is high, then 1.
